// File: rtl/capture_cmd_hub_if.sv
// Hub register bus and return-FIFO handshake for capture_cmd_hub.
// The master modport is the hub/FIFO side; the slave modport is the command front-end.
interface capture_cmd_hub_if #(
    parameter int RETURN_WIDTH = 128
);
    logic [63:0]             regIn;
    logic [63:0]             regOut;
    logic [7:0]              command;
    logic                    command_strobe;
    logic [7:0]              status;
    logic                    has_return_data;
    logic [RETURN_WIDTH-1:0] return_data;
    logic                    get_return_data;

    modport master (
        output regIn, command, command_strobe, has_return_data, return_data,
        input  regOut, status, get_return_data
    );

    modport slave (
        input  regIn, command, command_strobe, has_return_data, return_data,
        output regOut, status, get_return_data
    );
endinterface

// File: rtl/capture_cmd_hub.sv
// Command decoder, capture/trigger configuration store and return-word serialiser
// for the logic-capture peripheral.
module capture_cmd_hub #(
    parameter int SAMPLE_WIDTH = 32,
    parameter int RETURN_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    reset,
    capture_cmd_hub_if.slave        bus,
    input  logic                    core_idle,
    input  logic                    core_pre,
    input  logic                    core_post,
    input  logic [31:0]             trace_size,
    input  logic [31:0]             trig_sample,
    output logic                    start_pulse,
    output logic                    abort_pulse,
    output logic                    read_pulse,
    output logic                    core_reset,
    output logic [31:0]             max_sample_count,
    output logic [31:0]             pre_trigger_count,
    output logic [SAMPLE_WIDTH-1:0] desired_pattern,
    output logic [SAMPLE_WIDTH-1:0] active_channels,
    output logic [SAMPLE_WIDTH-1:0] dont_care,
    output logic [7:0]              edge_channel,
    output logic                    pattern_en,
    output logic                    edge_en,
    output logic                    edge_type
);
    localparam int CW = (SAMPLE_WIDTH + 31) / 32;
    localparam int PW = CW * 32;
    localparam int NB = RETURN_WIDTH / 64;
    localparam int BW = $clog2(NB) + 1;
    localparam logic [PW-1:0] MASK = PW'({SAMPLE_WIDTH{1'b1}});

    localparam logic [7:0] C_START  = 8'h01, C_ABORT = 8'h02, C_CFG_WR = 8'h03,
                           C_READ   = 8'h05, C_SIZE  = 8'h06, C_TRIG   = 8'h07,
                           C_ACK    = 8'h08, C_RESET = 8'h09, C_CFG_RD = 8'h0B,
                           C_NOP    = 8'h00;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LOAD, S_PRESENT} state_t;
    state_t r_state, w_next;

    logic [7:0]              r_cmd;
    logic                    r_stb, r_ack, r_err, r_first;
    logic [63:0]             r_regout;
    logic                    r_start, r_abort, r_read, r_core_rst;
    logic [31:0]             r_max, r_pre;
    logic [PW-1:0]           r_pat, r_act, r_dc;
    logic [10:0]             r_edge;
    logic [RETURN_WIDTH-1:0] r_word;
    logic [BW-1:0]           r_beat;

    logic [7:0]  w_field, w_idx;
    logic [31:0] w_data, w_rd_word;
    logic w_busy, w_known, w_reject, w_do, w_addr_ok, w_cfg_bad, w_start_bad;
    logic w_rd, w_pop, w_present_load, w_present_buf, w_set_ack, w_set_err, w_flush;
    logic w_unused;

    function automatic logic [PW-1:0] put_word(input logic [PW-1:0] cur,
                                               input logic [7:0] idx,
                                               input logic [31:0] d);
        logic [PW-1:0] v;
        v = cur;
        v[idx*32 +: 32] = d;
        return v & MASK;
    endfunction

    assign w_field  = bus.regIn[63:56];
    assign w_idx    = bus.regIn[55:48];
    assign w_data   = bus.regIn[31:0];
    assign w_unused = ^bus.regIn[47:32];

    always_comb begin
        w_addr_ok = 1'b0;
        w_rd_word = '0;
        case (w_field)
            8'd0: begin w_addr_ok = (w_idx == 8'd0); w_rd_word = r_max; end
            8'd1: begin w_addr_ok = (w_idx == 8'd0); w_rd_word = r_pre; end
            8'd2: begin w_addr_ok = (int'(w_idx) < CW); if (w_addr_ok) w_rd_word = r_pat[w_idx*32 +: 32]; end
            8'd3: begin w_addr_ok = (int'(w_idx) < CW); if (w_addr_ok) w_rd_word = r_act[w_idx*32 +: 32]; end
            8'd4: begin w_addr_ok = (int'(w_idx) < CW); if (w_addr_ok) w_rd_word = r_dc[w_idx*32 +: 32]; end
            8'd5: begin w_addr_ok = (w_idx == 8'd0); w_rd_word = {21'd0, r_edge}; end
            default: ;
        endcase
    end

    // Busy covers waiting on the FIFO and the cycle the popped word is being presented.
    assign w_busy      = (r_state == S_WAIT) || (r_state == S_LOAD);
    assign w_known     = r_cmd inside {C_NOP, C_START, C_ABORT, C_CFG_WR, C_READ, C_SIZE,
                                       C_TRIG, C_ACK, C_RESET, C_CFG_RD};
    assign w_reject    = r_stb && (!w_known ||
                         (w_busy && !(r_cmd inside {C_ABORT, C_RESET, C_ACK})));
    assign w_do        = r_stb && !w_reject;
    assign w_rd        = w_do && (r_cmd == C_READ);
    assign w_flush     = w_do && (r_cmd == C_ABORT || r_cmd == C_RESET);
    assign w_cfg_bad   = w_do && (r_cmd == C_CFG_WR || r_cmd == C_CFG_RD) && !w_addr_ok;
    assign w_start_bad = w_do && (r_cmd == C_START) && !core_idle;
    assign w_set_err   = w_reject || w_cfg_bad || w_start_bad;
    assign w_set_ack   = w_present_load || w_present_buf ||
                         (w_do && !w_cfg_bad && !w_start_bad &&
                          (r_cmd inside {C_START, C_ABORT, C_CFG_WR, C_SIZE, C_TRIG, C_RESET, C_CFG_RD}));

    always_comb begin
        w_next         = r_state;
        w_pop          = 1'b0;
        w_present_load = 1'b0;
        w_present_buf  = 1'b0;
        if (w_flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_rd) begin
                    if (bus.has_return_data) begin
                        w_pop  = 1'b1;
                        w_next = S_LOAD;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
                S_WAIT: if (bus.has_return_data) begin
                    w_pop  = 1'b1;
                    w_next = S_LOAD;
                end
                S_LOAD: begin
                    w_present_load = 1'b1;
                    w_next         = (NB > 1) ? S_PRESENT : S_IDLE;
                end
                S_PRESENT: if (w_rd) begin
                    w_present_buf = 1'b1;
                    if (r_beat == BW'(NB - 1)) w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd <= '0; r_stb <= 1'b0; r_ack <= 1'b0; r_err <= 1'b0; r_first <= 1'b1;
            r_regout <= '0;
            r_start <= 1'b0; r_abort <= 1'b0; r_read <= 1'b0; r_core_rst <= 1'b0;
            r_max <= 32'd100; r_pre <= '0; r_pat <= '0; r_act <= MASK; r_dc <= MASK;
            r_edge <= '0; r_word <= '0; r_beat <= '0;
        end else begin
            r_cmd      <= bus.command;
            r_stb      <= bus.command_strobe;
            r_start    <= w_do && (r_cmd == C_START) && core_idle;
            r_abort    <= w_do && (r_cmd == C_ABORT);
            r_core_rst <= w_do && (r_cmd == C_RESET);
            r_read     <= w_rd && r_first;

            if (w_flush)   r_first <= 1'b1;
            else if (w_rd) r_first <= 1'b0;

            if (w_do && (r_cmd == C_ACK)) begin
                r_ack <= 1'b0;
                r_err <= 1'b0;
            end
            if (w_set_err) r_err <= 1'b1;
            if (w_set_ack) r_ack <= 1'b1;

            if (w_do && (r_cmd == C_CFG_RD) && w_addr_ok) r_regout <= {32'd0, w_rd_word};
            if (w_do && (r_cmd == C_SIZE))                 r_regout <= {32'd0, trace_size};
            if (w_do && (r_cmd == C_TRIG))                 r_regout <= {32'd0, trig_sample};
            if (w_present_load)                            r_regout <= r_word[63:0];
            if (w_present_buf)                             r_regout <= r_word[r_beat*64 +: 64];

            if (w_pop) r_word <= bus.return_data;
            if (w_present_load)     r_beat <= BW'(1);
            else if (w_present_buf) r_beat <= r_beat + BW'(1);

            if (w_do && (r_cmd == C_CFG_WR) && w_addr_ok) begin
                case (w_field)
                    8'd0:    r_max  <= w_data;
                    8'd1:    r_pre  <= w_data;
                    8'd2:    r_pat  <= put_word(r_pat, w_idx, w_data);
                    8'd3:    r_act  <= put_word(r_act, w_idx, w_data);
                    8'd4:    r_dc   <= put_word(r_dc, w_idx, w_data);
                    8'd5:    r_edge <= w_data[10:0];
                    default: ;
                endcase
            end else if (w_do && (r_cmd == C_RESET)) begin
                r_max <= 32'd100; r_pre <= '0; r_pat <= '0; r_act <= MASK; r_dc <= MASK;
                r_edge <= '0; r_word <= '0; r_beat <= '0;
            end
        end
    end

    assign bus.regOut          = r_regout;
    assign bus.status          = {2'b00, r_err, w_busy, r_ack, core_post, core_pre, core_idle};
    assign bus.get_return_data = w_pop;
    assign start_pulse         = r_start;
    assign abort_pulse         = r_abort;
    assign read_pulse          = r_read;
    assign core_reset          = r_core_rst;
    assign max_sample_count    = r_max;
    assign pre_trigger_count   = r_pre;
    assign desired_pattern     = r_pat[SAMPLE_WIDTH-1:0];
    assign active_channels     = r_act[SAMPLE_WIDTH-1:0];
    assign dont_care           = r_dc[SAMPLE_WIDTH-1:0];
    assign edge_channel        = r_edge[7:0];
    assign pattern_en          = r_edge[8];
    assign edge_en             = r_edge[9];
    assign edge_type           = r_edge[10];
endmodule

// File: tb/tb_capture_cmd_hub.sv
// Scoreboard bench for capture_cmd_hub: stimulus queues expected regOut/status/pulse
// snapshots per cycle; a monitor pops and compares them on the falling edge.
module tb_capture_cmd_hub;
    localparam int SW = 40;
    localparam int RW = 128;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    capture_cmd_hub_if #(.RETURN_WIDTH(RW)) bus ();

    logic          core_idle, core_pre, core_post;
    logic [31:0]   trace_size, trig_sample;
    logic          start_pulse, abort_pulse, read_pulse, core_reset;
    logic [31:0]   max_sample_count, pre_trigger_count;
    logic [SW-1:0] desired_pattern, active_channels, dont_care;
    logic [7:0]    edge_channel;
    logic          pattern_en, edge_en, edge_type;

    capture_cmd_hub #(.SAMPLE_WIDTH(SW), .RETURN_WIDTH(RW)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .core_idle(core_idle), .core_pre(core_pre), .core_post(core_post),
        .trace_size(trace_size), .trig_sample(trig_sample),
        .start_pulse(start_pulse), .abort_pulse(abort_pulse),
        .read_pulse(read_pulse), .core_reset(core_reset),
        .max_sample_count(max_sample_count), .pre_trigger_count(pre_trigger_count),
        .desired_pattern(desired_pattern), .active_channels(active_channels),
        .dont_care(dont_care), .edge_channel(edge_channel),
        .pattern_en(pattern_en), .edge_en(edge_en), .edge_type(edge_type)
    );

    typedef struct {
        string       name;
        int          due;
        logic [63:0] ro;
        logic [2:0]  st;    // {error, busy, ack}
        logic [3:0]  pl;    // {start, abort, read, core_reset}
        int          pops;
    } exp_t;

    exp_t q[$];
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int pops_seen = 0;

    localparam logic [127:0] W1 = 128'h112233445566778899AABBCCDDEEFF00;
    localparam logic [127:0] W2 = 128'hFEDCBA9876543210_0123456789ABCDEF;
    localparam logic [63:0]  W1_LO = 64'h99AABBCCDDEEFF00, W1_HI = 64'h1122334455667788;
    localparam logic [63:0]  W2_LO = 64'h0123456789ABCDEF, W2_HI = 64'hFEDCBA9876543210;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (bus.get_return_data === 1'b1) pops_seen++;
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            logic [2:0] a_st;
            logic [3:0] a_pl;
            e    = q.pop_front();
            a_st = bus.status[5:3];
            a_pl = {start_pulse, abort_pulse, read_pulse, core_reset};
            checks++;
            if (bus.regOut !== e.ro || a_st !== e.st || a_pl !== e.pl || pops_seen != e.pops) begin
                failures++;
                $display("FAIL %s: got regOut=%h st=%b pl=%b pops=%0d, want regOut=%h st=%b pl=%b pops=%0d",
                         e.name, bus.regOut, a_st, a_pl, pops_seen, e.ro, e.st, e.pl, e.pops);
            end
        end
    end

    task automatic push_exp(input string n, input int d, input logic [63:0] ro,
                            input logic [2:0] st, input logic [3:0] pl, input int pops);
        exp_t e;
        e = '{n, cyc + d, ro, st, pl, pops};
        q.push_back(e);
    endtask

    task automatic check_val(input string n, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h, want %h", n, act, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmd(input logic [7:0] c, input logic [63:0] rin);
        @(posedge clk);
        #1;
        bus.command        = c;
        bus.regIn          = rin;
        bus.command_strobe = 1'b1;
        @(posedge clk);
        #1;
        bus.command_strobe = 1'b0;
    endtask

    initial begin
        bus.regIn = '0; bus.command = '0; bus.command_strobe = 1'b0;
        bus.has_return_data = 1'b0; bus.return_data = '0;
        core_idle = 1'b1; core_pre = 1'b0; core_post = 1'b0;
        trace_size = 32'hDEADBEEF; trig_sample = 32'hCAFEF00D;

        tick(3);
        reset = 1'b1;
        push_exp("reset_state", 0, 64'h0, 3'b000, 4'b0000, 0);
        tick(1);
        check_val("rst_max", {32'd0, max_sample_count}, 64'd100);
        check_val("rst_active", {24'd0, active_channels}, 64'h00FF_FFFF_FFFF);

        cmd(8'h0B, 64'h0);
        push_exp("cfg_rd_max", 1, 64'h64, 3'b001, 4'b0000, 0); tick(2);
        cmd(8'h03, 64'h0201_0000_FFFF_FFFF);
        push_exp("cfg_wr_pat1", 1, 64'h64, 3'b001, 4'b0000, 0); tick(2);
        check_val("pattern_hi", {24'd0, desired_pattern}, 64'hFF_0000_0000);
        cmd(8'h0B, 64'h0201_0000_0000_0000);
        push_exp("cfg_rd_pat1", 1, 64'hFF, 3'b001, 4'b0000, 0); tick(2);
        cmd(8'h03, 64'h0202_0000_1234_5678);
        push_exp("cfg_bad_idx", 1, 64'hFF, 3'b101, 4'b0000, 0); tick(2);
        check_val("pattern_kept", {24'd0, desired_pattern}, 64'hFF_0000_0000);
        cmd(8'h08, 64'h0);
        push_exp("ack_clear", 1, 64'hFF, 3'b000, 4'b0000, 0); tick(2);
        cmd(8'h03, 64'h0600_0000_0000_0001);
        push_exp("cfg_bad_field", 1, 64'hFF, 3'b100, 4'b0000, 0); tick(2);
        cmd(8'h08, 64'h0);
        push_exp("ack_clear2", 1, 64'hFF, 3'b000, 4'b0000, 0); tick(2);

        cmd(8'h03, 64'h0500_0000_0000_0605);
        push_exp("cfg_wr_edge", 1, 64'hFF, 3'b001, 4'b0000, 0); tick(2);
        check_val("edge_cfg", {53'd0, edge_type, edge_en, pattern_en, edge_channel}, 64'h605);
        cmd(8'h0B, 64'h0500_0000_0000_0000);
        push_exp("cfg_rd_edge", 1, 64'h605, 3'b001, 4'b0000, 0); tick(2);

        core_idle = 1'b0;
        cmd(8'h01, 64'h0);
        push_exp("start_not_idle", 1, 64'h605, 3'b101, 4'b0000, 0); tick(2);
        core_idle = 1'b1;
        cmd(8'h08, 64'h0);
        push_exp("ack_after_err", 1, 64'h605, 3'b000, 4'b0000, 0); tick(2);
        cmd(8'h01, 64'h0);
        push_exp("start_ok", 1, 64'h605, 3'b001, 4'b1000, 0);
        push_exp("start_width", 2, 64'h605, 3'b001, 4'b0000, 0); tick(3);
        cmd(8'h04, 64'h0);
        push_exp("bad_code", 1, 64'h605, 3'b101, 4'b0000, 0); tick(2);
        cmd(8'h08, 64'h0);
        push_exp("ack_clear3", 1, 64'h605, 3'b000, 4'b0000, 0); tick(2);
        cmd(8'h07, 64'hFFFF_FFFF_FFFF_FFFF);
        push_exp("trig_sample", 1, 64'hCAFEF00D, 3'b001, 4'b0000, 0); tick(2);
        cmd(8'h06, 64'hFFFF_FFFF_FFFF_FFFF);
        push_exp("trace_size", 1, 64'hDEADBEEF, 3'b001, 4'b0000, 0); tick(2);

        bus.return_data = W1; bus.has_return_data = 1'b1;
        cmd(8'h05, 64'h0);
        push_exp("rd_pop", 1, 64'hDEADBEEF, 3'b011, 4'b0010, 1);
        push_exp("rd_w1_beat0", 2, W1_LO, 3'b001, 4'b0000, 1);
        tick(1); bus.has_return_data = 1'b0; tick(2);
        cmd(8'h05, 64'h0);
        push_exp("rd_w1_beat1", 1, W1_HI, 3'b001, 4'b0000, 1); tick(2);
        cmd(8'h05, 64'h0);
        push_exp("rd_wait", 1, W1_HI, 3'b011, 4'b0000, 1);
        push_exp("rd_wait_hold", 3, W1_HI, 3'b011, 4'b0000, 1); tick(4);
        bus.return_data = W2; bus.has_return_data = 1'b1;
        push_exp("rd_w2_pop", 1, W1_HI, 3'b011, 4'b0000, 2);
        push_exp("rd_w2_beat0", 2, W2_LO, 3'b001, 4'b0000, 2);
        tick(1); bus.has_return_data = 1'b0; tick(2);
        cmd(8'h05, 64'h0);
        push_exp("rd_w2_beat1", 1, W2_HI, 3'b001, 4'b0000, 2); tick(2);

        cmd(8'h05, 64'h0);
        push_exp("rd_wait2", 1, W2_HI, 3'b011, 4'b0000, 2); tick(2);
        cmd(8'h05, 64'h0);
        push_exp("busy_reject", 1, W2_HI, 3'b111, 4'b0000, 2); tick(2);
        cmd(8'h02, 64'h0);
        push_exp("abort", 1, W2_HI, 3'b101, 4'b0100, 2);
        push_exp("abort_width", 2, W2_HI, 3'b101, 4'b0000, 2); tick(3);
        cmd(8'h08, 64'h0);
        push_exp("ack_clear4", 1, W2_HI, 3'b000, 4'b0000, 2); tick(2);
        cmd(8'h05, 64'h0);
        push_exp("rd_after_abort", 1, W2_HI, 3'b010, 4'b0010, 2); tick(2);

        reset = 1'b0; bus.has_return_data = 1'b1;
        push_exp("async_rst", 0, 64'h0, 3'b000, 4'b0000, 2);
        push_exp("async_rst_hold", 1, 64'h0, 3'b000, 4'b0000, 2); tick(2);
        check_val("rst_pattern", {24'd0, desired_pattern}, 64'h0);
        check_val("rst_edge", {53'd0, edge_type, edge_en, pattern_en, edge_channel}, 64'h0);
        reset = 1'b1; bus.has_return_data = 1'b0; tick(1);

        cmd(8'h03, 64'h0000_0000_0000_0200);
        push_exp("cfg_wr_max", 1, 64'h0, 3'b001, 4'b0000, 2); tick(2);
        check_val("max_written", {32'd0, max_sample_count}, 64'h200);
        cmd(8'h09, 64'h0);
        push_exp("reset_cmd", 1, 64'h0, 3'b001, 4'b0001, 2); tick(2);
        check_val("reset_cmd_max", {32'd0, max_sample_count}, 64'd100);

        for (int i = 0; i < 20 && q.size() > 0; i++) tick(1);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/capture_cmd_hub.md
# capture_cmd_hub

Parametrised command/register front-end for the logic-capture peripheral, generalised to sample widths beyond 16 channels and to arbitrary-width memory return words. It sits between the command/control hub (8 in/8 out byte registers plus command strobe) and the capture core and memory readback path. It decodes commands, holds the capture/trigger configuration and issues single-cycle control pulses. It also serialises `RETURN_WIDTH`-bit memory words into 64-bit register beats, and reports busy/error status the previous generation lacked.

## Interface
- `SAMPLE_WIDTH`, 32: channel count; 1..256.
- `RETURN_WIDTH`, 128: memory return word width; a multiple of 64.
- Derived: `CW = ceil(SAMPLE_WIDTH/32)` config words per channel field; `NB = RETURN_WIDTH/64` beats per return word.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `regIn`  in  64  hub input registers, byte k = `regIn[8k+7:8k]`.
- `regOut`  out  64  hub output registers, same packing.
- `command`  in  8  command code.
- `command_strobe`  in  1  command valid, one cycle.
- `status`  out  8  `{2'b0, error, busy, ack, core_post, core_pre, core_idle}`.
- `core_idle`, `core_pre`, `core_post`  in  1 each  capture core state.
- `trace_size`, `trig_sample`  in  32 each  core results.
- `start_pulse`, `abort_pulse`, `read_pulse`, `core_reset`  out  1 each  single-cycle pulses.
- `max_sample_count`, `pre_trigger_count`  out  32 each  buffer configuration.
- `desired_pattern`, `active_channels`, `dont_care`  out  `SAMPLE_WIDTH` each  trigger configuration.
- `edge_channel`  out  8.
- `pattern_en`, `edge_en`, `edge_type`  out  1 each.
- `has_return_data`  in  1  show-ahead return FIFO not empty.
- `return_data`  in  `RETURN_WIDTH`  FIFO head, valid while `has_return_data` is high.
- `get_return_data`  out  1  pop, one cycle.

## Operation
- Codes: 00 NOP, 01 START, 02 ABORT, 03 CFG_WRITE, 05 READ_TRACE_DATA, 06 READ_TRACE_SIZE, 07 READ_TRIG_SAMPLE, 08 ACK, 09 RESET, 0B CFG_READ. Any other code sets `error`; no other effect.
- Config addressing: `regIn` byte 7 = field, byte 6 = word index, bytes 3..0 = 32-bit data (little-endian).
  - Fields: 0 max count, 1 pre-trigger, 2 pattern, 3 active, 4 dont-care, 5 edge.
  - Edge word layout: `[7:0]` channel, `[8]` pattern_en, `[9]` edge_en, `[10]` edge_type.
  - Fields 2-4 accept index 0..CW-1. Word i maps to bits `[32i+31:32i]`; bits above `SAMPLE_WIDTH` are dropped on write and read back as 0.
  - Fields 0, 1, 5 accept index 0 only.
  - A bad field or bad index sets `error`, writes nothing and does not set `ack`.
- CFG_READ returns the addressed word in bytes 3..0 and zeroes bytes 7..4.
- READ_TRACE_SIZE and READ_TRIG_SAMPLE load bytes 3..0 and zero bytes 7..4.
- START: if `core_idle`=1, pulses `start_pulse` and sets `ack`; otherwise sets `error`.
- ABORT: pulses `abort_pulse`, cancels any pending readback and sets `ack`.
- RESET: restores config defaults, pulses `core_reset`, clears the beat buffer and sets `ack`.
- ACK: clears `ack` and `error`.
- Readback FSM states: IDLE, WAIT, LOAD, PRESENT.
  - READ_TRACE_DATA pulses `read_pulse` on the first request after reset, RESET or ABORT.
  - If beats remain in the buffer, present the next beat: beat j = `word[64j+63:64j]`. Set `ack`. No pop.
  - If the buffer is empty, go to WAIT. Raise `busy` until `has_return_data`.
  - Then pop with `get_return_data` and latch `return_data` the same cycle. Next cycle present beat 0 and set `ack`.
  - After beat NB-1 has been presented, the buffer is empty.
- While `busy`=1, every command except ABORT, RESET and ACK sets `error` and is ignored.
- Reset values:
  - `regOut`: 0.
  - `ack`, `error`, `busy`: 0. All pulses and `get_return_data`: 0.
  - Max count: 100. Pre-trigger: 0. Pattern: 0.
  - Active and dont-care: all ones. Edge channel and enables: 0.
  - Beat buffer: empty.

## Timing
- `command` and `command_strobe` are registered at edge N. Effects, including pulses, register loads and `ack`, are visible after edge N+1.
- Pulses are exactly one cycle wide.
- Readback with data already available: strobe at N, `get_return_data` high in cycle N+1, regOut loaded after N+2.
- A strobe arriving in the same cycle as a completing readback is registered normally. It is judged against `busy` as seen in its execute cycle.
- Asynchronous reset asserted mid-readback aborts the sequence. No `get_return_data` is issued after reset assertion.
- `has_return_data` dropping during WAIT holds the FSM in WAIT. A pop is never issued without `has_return_data`=1.

## Test plan
- Reset, then CFG_READ field 0 -> regOut = 0x00000000_00000064, status `ack`=1.
- `SAMPLE_WIDTH`=40: CFG_WRITE field 2 idx 1 data 0xFFFFFFFF -> `desired_pattern`=0xFF_00000000; CFG_READ idx 1 -> 0x000000FF. CFG_WRITE idx 2 -> `error`=1, pattern unchanged.
- `RETURN_WIDTH`=128, FIFO word 0x1122..FF00: READ_TRACE_DATA x2 -> exactly one `get_return_data`, beats low then high. Third READ with FIFO empty -> `busy`=1. Push a word -> beat 0 of the new word, `busy`=0.
- START with `core_idle`=0 -> no `start_pulse`, `error`=1; ACK -> `error`=0 and `ack`=0.
- Command 0x05 in WAIT then ABORT -> first sets `error`; ABORT clears `busy` and pulses `abort_pulse` once, with no pop.
- Reset asserted while in WAIT with `has_return_data` rising simultaneously -> no pop; all outputs at reset values.
